vmem_dma: RTL

- Byte-copy DMA engine that moves blocks from data memory (0x0000-0x07FF) into video memory (0x2000-0x2960), or between any mapped addresses.
- Sits between the CPU's dMemIO bus and the memory-map address decoder.
- Shares that bus with the CPU; the CPU always has priority.
- Configured through an 8-byte register window in I/O space; raises a done flag on the CPU interrupt inputs.

---
 rtl/vmem_dma_pkg.sv | 34 +++
 rtl/vmem_dma_regs.sv | 112 +++++++++++
 rtl/vmem_dma.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vmem_dma_pkg.sv
// Shared encodings for vmem_dma: FSM states, config register offsets and CTRL/STATUS bits.
// FILL bit is only honoured when VMEM_DMA_FILL_EN is defined.
package vmem_dma_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    // Config register offsets
    localparam logic [2:0] REG_SRC_L  = 3'd0;
    localparam logic [2:0] REG_SRC_H  = 3'd1;
    localparam logic [2:0] REG_DST_L  = 3'd2;
    localparam logic [2:0] REG_DST_H  = 3'd3;
    localparam logic [2:0] REG_LEN_L  = 3'd4;
    localparam logic [2:0] REG_LEN_H  = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    // CTRL bits
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_FILL  = 2;

    // STATUS bits
    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;

    function automatic logic is_counter_reg(input logic [2:0] addr);
        return addr <= REG_LEN_H;
    endfunction

endpackage

// File: rtl/vmem_dma_regs.sv
// vmem_dma_regs: SRC/DST/LEN counters, CTRL decode, registered read mux and the done flag.
// The FILL request output only exists when VMEM_DMA_FILL_EN is defined.
module vmem_dma_regs
    import vmem_dma_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  cfg_address_i,
    input  logic [7:0]  cfg_din_i,
    input  logic        cfg_w_en_i,
    input  logic        cfg_r_en_i,
    input  logic        busy_i,
    input  logic        step_i,
    input  logic        src_hold_i,
    input  logic        done_set_i,
    input  logic        done_clr_i,
    output logic [15:0] src_o,
    output logic [15:0] dst_o,
    output logic [15:0] len_o,
    output logic        start_o,
    output logic        abort_o,
`ifdef VMEM_DMA_FILL_EN
    output logic        fill_o,
`endif
    output logic [7:0]  cfg_dout_o,
    output logic        done_flag_o
);

    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  cfg_dout_q, cfg_dout_d;
    logic        done_q, done_d;
    logic [7:0]  rd_data;
    logic        ctrl_wr;

    assign ctrl_wr = cfg_w_en_i && (cfg_address_i == REG_CTRL);
    assign abort_o = ctrl_wr && cfg_din_i[CTRL_ABORT];
    // ABORT in the same write suppresses START; START is ignored while busy.
    assign start_o = ctrl_wr && cfg_din_i[CTRL_START] && !cfg_din_i[CTRL_ABORT] && !busy_i;
`ifdef VMEM_DMA_FILL_EN
    assign fill_o  = cfg_din_i[CTRL_FILL];
`endif

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        if (cfg_w_en_i && !busy_i && is_counter_reg(cfg_address_i)) begin
            case (cfg_address_i)
                REG_SRC_L: src_d[7:0]  = cfg_din_i;
                REG_SRC_H: src_d[15:8] = cfg_din_i;
                REG_DST_L: dst_d[7:0]  = cfg_din_i;
                REG_DST_H: dst_d[15:8] = cfg_din_i;
                REG_LEN_L: len_d[7:0]  = cfg_din_i;
                REG_LEN_H: len_d[15:8] = cfg_din_i;
                default: ;
            endcase
        end
        if (step_i) begin
            if (!src_hold_i) begin
                src_d = src_q + 16'd1;
            end
            dst_d = dst_q + 16'd1;
            len_d = len_q - 16'd1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (cfg_address_i)
            REG_SRC_L: rd_data = src_q[7:0];
            REG_SRC_H: rd_data = src_q[15:8];
            REG_DST_L: rd_data = dst_q[7:0];
            REG_DST_H: rd_data = dst_q[15:8];
            REG_LEN_L: rd_data = len_q[7:0];
            REG_LEN_H: rd_data = len_q[15:8];
            REG_STATUS: begin
                rd_data[STATUS_BUSY] = busy_i;
                rd_data[STATUS_DONE] = done_q;
            end
            default: rd_data = 8'h00;
        endcase
    end

    assign cfg_dout_d = cfg_r_en_i ? rd_data : cfg_dout_q;
    // Completion beats a coincident acknowledge so no interrupt is lost.
    assign done_d     = done_set_i ? 1'b1 : (done_clr_i ? 1'b0 : done_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q      <= 16'h0000;
            dst_q      <= 16'h0000;
            len_q      <= 16'h0000;
            cfg_dout_q <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            cfg_dout_q <= cfg_dout_d;
            done_q     <= done_d;
        end
    end

    assign src_o       = src_q;
    assign dst_o       = dst_q;
    assign len_o       = len_q;
    assign cfg_dout_o  = cfg_dout_q;
    assign done_flag_o = done_q;

endmodule

// File: rtl/vmem_dma.sv
// vmem_dma: byte-copy DMA that shares the CPU data bus, yielding whenever the CPU is active.
// Constant-fill mode (CTRL bit2) is built in only when VMEM_DMA_FILL_EN is defined.
module vmem_dma
    import vmem_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_w_en,
    input  logic              cpu_r_en,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_din,
    output logic              bus_w_en,
    output logic              bus_r_en,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic [2:0]        cfg_address,
    input  logic [7:0]        cfg_din,
    input  logic              cfg_w_en,
    input  logic              cfg_r_en,
    output logic [7:0]        cfg_dout,
    output logic              done_flag,
    input  logic              done_flag_clr
);

    logic [1:0]  state_q, state_d;
    logic        cpu_rd_q;
    logic [7:0]  data_q, data_d;
    logic        own;
    logic        busy;
    logic        step;
    logic        done_set;
    logic        start;
    logic        abort;
    logic        fill_mode;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  wr_byte;

`ifdef VMEM_DMA_FILL_EN
    logic fill_q, fill_d, fill_req;
    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    // cpu_rd_q keeps the CPU address on the bus through its data-return cycle.
    assign own     = !cpu_w_en && !cpu_r_en && !cpu_rd_q;
    assign busy    = (state_q != ST_IDLE);
    assign wr_byte = fill_mode ? src[7:0] : data_q;

    vmem_dma_regs u_regs (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_address_i (cfg_address),
        .cfg_din_i     (cfg_din),
        .cfg_w_en_i    (cfg_w_en),
        .cfg_r_en_i    (cfg_r_en),
        .busy_i        (busy),
        .step_i        (step),
        .src_hold_i    (fill_mode),
        .done_set_i    (done_set),
        .done_clr_i    (done_flag_clr),
        .src_o         (src),
        .dst_o         (dst),
        .len_o         (len),
        .start_o       (start),
        .abort_o       (abort),
`ifdef VMEM_DMA_FILL_EN
        .fill_o        (fill_req),
`endif
        .cfg_dout_o    (cfg_dout),
        .done_flag_o   (done_flag)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        step     = 1'b0;
        done_set = 1'b0;
`ifdef VMEM_DMA_FILL_EN
        fill_d   = fill_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        done_set = 1'b1;
                    end else begin
`ifdef VMEM_DMA_FILL_EN
                        fill_d  = fill_req;
                        state_d = fill_req ? ST_WR : ST_RD;
`else
                        state_d = ST_RD;
`endif
                    end
                end
            end
            ST_RD: begin
                if (own) begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                // A CPU access here invalidates the returning byte, so read it again.
                if (own) begin
                    data_d  = 8'(bus_rdata);
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (own) begin
                    step = 1'b1;
                    if (len == 16'd1) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = fill_mode ? ST_WR : ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            done_set = 1'b0;
        end
    end

    always_comb begin
        bus_address = cpu_address;
        bus_din     = cpu_din;
        bus_w_en    = cpu_w_en;
        bus_r_en    = cpu_r_en;
        if (own) begin
            case (state_q)
                ST_RD: begin
                    bus_address = ADDR_W'(src);
                    bus_r_en    = 1'b1;
                end
                ST_CAP: bus_address = ADDR_W'(src);
                ST_WR: begin
                    bus_address = ADDR_W'(dst);
                    bus_din     = DATA_W'(wr_byte);
                    bus_w_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cpu_rd_q <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cpu_rd_q <= cpu_r_en;
            data_q   <= data_d;
        end
    end

`ifdef VMEM_DMA_FILL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end
`endif

endmodule
